// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined adder/subtractor, one CHUNK-bit carry stage per register stage.
// Operands ride alongside the carry chain; resolved result chunks accumulate stage by stage.
module pipe_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int L = STAGES - 1;

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             s_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];
    logic             s_d [STAGES];
    logic [WIDTH-1:0] r_i [STAGES];
    logic             c_i [STAGES];
    logic [CHUNK:0]   t;
    logic             en;

    assign en        = !v_q[L] || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[L];
    assign y         = {c_q[L] ^ s_q[L], r_q[L]};
    assign ovf       = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (r_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

    always_comb begin
        a_d[0] = a;
        b_d[0] = b ^ {WIDTH{sub}};
        v_d[0] = in_valid;
        s_d[0] = sub;
        r_i[0] = '0;
        c_i[0] = sub;
        for (int s = 1; s < STAGES; s++) begin
            a_d[s] = a_q[s-1];
            b_d[s] = b_q[s-1];
            v_d[s] = v_q[s-1];
            s_d[s] = s_q[s-1];
            r_i[s] = r_q[s-1];
            c_i[s] = c_q[s-1];
        end
        t = '0;
        // Stage s resolves only chunk s; lower chunks pass through already final.
        for (int s = 0; s < STAGES; s++) begin
            t = {1'b0, a_d[s][s*CHUNK +: CHUNK]} + {1'b0, b_d[s][s*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_i[s]};
            r_d[s] = r_i[s];
            r_d[s][s*CHUNK +: CHUNK] = t[CHUNK-1:0];
            c_d[s] = t[CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
                r_q[s] <= '0;
                c_q[s] <= 1'b0;
                v_q[s] <= 1'b0;
                s_q[s] <= 1'b0;
            end
        end else if (en) begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
            c_q <= c_d;
            v_q <= v_d;
            s_q <= s_d;
        end
    end
endmodule

// File: doc/pipe_add_sub.md
# pipe_add_sub

Parametrised, pipelined adder/subtractor. Splits a WIDTH-bit carry chain into CHUNK-bit stages, one register stage per chunk, so wide operands close timing at full clock rate. Operands enter through a valid/ready handshake; results leave through a matching handshake with a carry/borrow bit and a signed-overflow flag. Sits wherever the datapath needs a registered, back-pressurable add/sub, and generalises the 4-bit combinational adder.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4, bits resolved per pipeline stage.
- STAGES (localparam), WIDTH/CHUNK, pipeline depth.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A (unsigned, or two's complement for ovf).
- b  in  WIDTH  operand B.
- sub  in  1  0: add, 1: subtract (a - b).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  WIDTH+1  result: y[WIDTH] is carry (add) or borrow (sub), y[WIDTH-1:0] is the sum/difference mod 2^WIDTH.
- ovf  out  1  two's-complement overflow of y[WIDTH-1:0].

## Operation
- Arithmetic: s = a + (b XOR {WIDTH{sub}}) + sub, computed with a WIDTH+1-bit carry chain. y[WIDTH-1:0] = s[WIDTH-1:0]. y[WIDTH] = carry_out XOR sub, so add gives a carry and subtract gives a borrow (1 when a < b unsigned). ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the conditioned B.
- Stage s (0..STAGES-1) adds chunk s of A and B' plus the carry registered by stage s-1. Stage 0 uses sub as its carry-in. Each stage registers the following: its chunk result, its carry, a valid bit, the sub bit, the not-yet-consumed upper operand chunks, and the already-resolved lower result chunks (skew/deskew registers).
- The last stage's registers drive y, ovf and out_valid directly. Outputs are registered, with no combinational path from a/b.
- Global advance enable: en = !out_valid || out_ready. in_ready = en, a combinational function of out_valid and out_ready only, never of in_valid.
- Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
- When en = 0, every stage holds, including valid bits and data.
- When en = 1, every stage shifts. A stage whose predecessor is empty loads valid = 0. Bubbles are not collapsed.
- Reset (asynchronous, any time): all valid bits 0, out_valid = 0, y = 0, ovf = 0. In-flight operations are discarded. Operation resumes on the first edge after rst_n rises.

## Timing
- Latency: operands accepted at edge k appear with out_valid = 1 after edge k+STAGES-1, i.e. in the STAGES-th cycle. With defaults, accept at edge 0 gives the result visible after edge 3.
- Throughput: one result per cycle while out_ready = 1. Order is preserved.
- While out_valid = 1 and out_ready = 0, y and ovf are stable and in_ready = 0.
- A simultaneous output transfer and input transfer in the same cycle is legal and required for full throughput.
- STAGES = 1 (CHUNK = WIDTH) degenerates to a single registered add/sub with latency 1.
- Operand, sub and in_valid values are sampled only on transfer edges. Values outside transfers are don't-care.

## Test plan
- WIDTH=16, CHUNK=4, out_ready=1. Single add a=0x00FF, b=0x0001 → 4 cycles later y=0x00100, ovf=0. Carry crosses chunk boundaries twice.
- Add a=0xFFFF, b=0x0001 → y=0x10000 (carry set). Add a=0x7FFF, b=0x0001 → y=0x08000, ovf=1.
- Subtract a=5, b=7 → y=0x1FFFE (borrow set), ovf=0. Subtract a=0x8000, b=1 → y=0x07FFF, ovf=1.
- Back-to-back stream of 10 random add/sub ops with out_ready=1 → 10 consecutive out_valid cycles, each y equal to the reference model, in order. Then hold out_ready=0 for 3 cycles mid-stream → in_ready=0, y stable, no loss or duplication.
- Assert rst_n low asynchronously (mid-clock) with 3 ops in flight → out_valid, y and ovf drop to 0 immediately. After release, a new op a=3, b=4 yields y=7 and no stale results appear.
- Repeat the directed add/sub checks with WIDTH=8, CHUNK=8 (latency 1) and WIDTH=32, CHUNK=8 (latency 4).
